// File: rtl/led_sequencer.sv
// LED pattern engine: fill / chase / bounce / blink animations over N_LEDS outputs.
// Latency: start edge accepted at edge k shows frame 0 after edge k; each frame lasts TICK_DIV cycles.
// No backpressure: start edges while busy are dropped, abort clears the run at the next edge.
module led_sequencer #(
  parameter int N_LEDS   = 5,
  parameter int TICK_DIV = 8388608,
  parameter int REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [REPEAT_W-1:0] repeats,
  input  logic                abort,
  output logic [N_LEDS-1:0]   led,
  output logic                busy,
  output logic                done
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = $clog2(2 * N_LEDS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic                start_q, start_d;
  logic [1:0]          mode_q, mode_d;
  logic [REPEAT_W-1:0] rep_q, rep_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic [REPEAT_W-1:0] pass_q, pass_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic                done_q, done_d;

  logic                accept;
  logic [REPEAT_W-1:0] pass_inc;
  logic [FW-1:0]       frame_inc;

  // LED image for frame f of animation m.
  function automatic logic [N_LEDS-1:0] frame_pattern(input logic [1:0] m, input logic [FW-1:0] f);
    int fi;
    int pos;
    logic [N_LEDS-1:0] p;
    fi  = int'(f);
    p   = '0;
    // Bounce walks up to the top LED, then back down without repeating either end.
    pos = (fi < N_LEDS) ? fi : (2 * N_LEDS - 2 - fi);
    for (int b = 0; b < N_LEDS; b++) begin
      case (m)
        2'd0:    p[b] = (b <= fi) && (fi < N_LEDS);
        2'd1:    p[b] = (b == fi);
        2'd2:    p[b] = (b == pos);
        default: p[b] = (fi == 0);
      endcase
    end
    return p;
  endfunction

  // Index of the final frame of one pass for animation m.
  function automatic logic [FW-1:0] frame_last(input logic [1:0] m);
    case (m)
      2'd0:    return FW'(N_LEDS);
      2'd1:    return FW'(N_LEDS - 1);
      2'd2:    return FW'(2 * N_LEDS - 3);
      default: return FW'(1);
    endcase
  endfunction

  // A start is a fresh rising edge seen while idle and not being aborted.
  assign accept    = start && !start_q && (state_q == S_IDLE) && !abort;
  // Pass counter saturates so an endless run never wraps back to a small count.
  assign pass_inc  = (&pass_q) ? pass_q : pass_q + REPEAT_W'(1);
  assign frame_inc = frame_q + FW'(1);

  // Next-state logic: start acceptance, frame ticking, pass wrap, completion and abort.
  always_comb begin
    state_d = state_q;
    start_d = start;
    mode_d  = mode_q;
    rep_d   = rep_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    pass_d  = pass_q;
    led_d   = led_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          mode_d  = mode;
          rep_d   = repeats;
          tick_d  = '0;
          frame_d = '0;
          pass_d  = '0;
          led_d   = frame_pattern(mode, '0);
        end
      end
      default: begin
        if (abort) begin
          state_d = S_IDLE;
          tick_d  = '0;
          frame_d = '0;
          pass_d  = '0;
          led_d   = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (frame_q == frame_last(mode_q)) begin
            frame_d = '0;
            pass_d  = pass_inc;
            if ((rep_q != '0) && (pass_inc == rep_q)) begin
              state_d = S_IDLE;
              pass_d  = '0;
              led_d   = '0;
              done_d  = 1'b1;
            end else begin
              led_d = frame_pattern(mode_q, '0);
            end
          end else begin
            frame_d = frame_inc;
            led_d   = frame_pattern(mode_q, frame_inc);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
    endcase
  end

  // State register; start_q resets high so a start held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b1;
      mode_q  <= '0;
      rep_q   <= '0;
      tick_q  <= '0;
      frame_q <= '0;
      pass_q  <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      rep_q   <= rep_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      pass_q  <= pass_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q == S_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: three instances (TICK_DIV 4, 1, 2) share one stimulus stream.
// Expected outputs come from a cycle-count model: frame = elapsed / TICK_DIV, pass = frame / F.
module tb_led_sequencer;
  localparam int N  = 5;
  localparam int RW = 4;
  localparam int VW = 3 * (N + 2);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b1;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [RW-1:0] repeats = '0;

  logic [N-1:0] led0, led1, led2;
  logic         busy0, busy1, busy2;
  logic         done0, done1, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_sequencer #(.N_LEDS(N), .TICK_DIV(4), .REPEAT_W(RW)) u0 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .repeats(repeats),
    .abort(abort), .led(led0), .busy(busy0), .done(done0));
  led_sequencer #(.N_LEDS(N), .TICK_DIV(1), .REPEAT_W(RW)) u1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .repeats(repeats),
    .abort(abort), .led(led1), .busy(busy1), .done(done1));
  led_sequencer #(.N_LEDS(N), .TICK_DIV(2), .REPEAT_W(RW)) u2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .repeats(repeats),
    .abort(abort), .led(led2), .busy(busy2), .done(done2));

  // ---------------- reference model ----------------
  function automatic int td_of(int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int frames(int m);
    case (m)
      0:       return N + 1;
      1:       return N;
      2:       return 2 * N - 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [N-1:0] pat(int m, int f);
    int x;
    int pos;
    case (m)
      0: x = (f < N) ? ((1 << (f + 1)) - 1) : 0;
      1: x = 1 << f;
      2: begin
        pos = (f < N) ? f : (2 * N - 2 - f);
        x = 1 << pos;
      end
      default: x = (f == 0) ? ((1 << N) - 1) : 0;
    endcase
    return x[N-1:0];
  endfunction

  logic         m_act[3];
  logic         m_done[3];
  logic [N-1:0] m_led[3];
  int           m_n[3];
  int           m_mode[3];
  int           m_rep[3];
  logic         m_prev;
  int           mfr, mff;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 1'b0;
      if (reset) begin
        m_act[i] = 1'b0;
        m_led[i] = '0;
      end else if (m_act[i]) begin
        if (abort) begin
          m_act[i] = 1'b0;
          m_led[i] = '0;
        end else begin
          m_n[i] = m_n[i] + 1;
          mfr = m_n[i] / td_of(i);
          mff = frames(m_mode[i]);
          if (m_rep[i] != 0 && (mfr / mff) >= m_rep[i]) begin
            m_act[i]  = 1'b0;
            m_led[i]  = '0;
            m_done[i] = 1'b1;
          end else begin
            m_led[i] = pat(m_mode[i], mfr % mff);
          end
        end
      end else if (start && !m_prev && !abort) begin
        m_act[i]  = 1'b1;
        m_n[i]    = 0;
        m_mode[i] = int'(mode);
        m_rep[i]  = int'(repeats);
        m_led[i]  = pat(int'(mode), 0);
      end
    end
    m_prev = reset ? 1'b1 : start;
  end

  logic [VW-1:0] obs, exp_vec;
  assign obs = {led0, busy0, done0, led1, busy1, done1, led2, busy2, done2};
  always_comb begin
    exp_vec = {m_led[0], m_act[0], m_done[0], m_led[1], m_act[1], m_done[1],
               m_led[2], m_act[2], m_done[2]};
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic edge_start();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) step();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", obs);
    end
  endtask

  task automatic test_start_held();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL held_start c=%0d got=%h want=%h", c, obs, exp_vec);
      end
    end
    checks++;
    if ({busy0, busy1, busy2} !== 3'b000) begin
      errors++;
      $display("FAIL held_start_no_run busy=%b want=000", {busy0, busy1, busy2});
    end
    mode = 2'd0;
    repeats = 4'd1;
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    checks++;
    if ({busy0, busy1, busy2} !== 3'b111 || led0 !== 5'b00001) begin
      errors++;
      $display("FAIL start_after_low busy=%b led0=%b want busy=111 led0=00001",
               {busy0, busy1, busy2}, led0);
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL held_abort_clear got=%h want=0", obs);
    end
  endtask

  task automatic test_fill();
    int bc, dc;
    bc = 0;
    dc = 0;
    mode = 2'd0;
    repeats = 4'd1;
    edge_start();
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL fill c=%0d got=%h want=%h", c, obs, exp_vec);
      end
      if (busy0) bc++;
      if (done0) begin
        dc++;
        checks++;
        if (led0 !== '0) begin
          errors++;
          $display("FAIL fill_done_led got=%b want=00000", led0);
        end
      end
      step();
    end
    checks++;
    if (bc != 24 || dc != 1) begin
      errors++;
      $display("FAIL fill_length busy=%0d done=%0d want busy=24 done=1", bc, dc);
    end
  endtask

  task automatic test_bounce();
    int bc, dc;
    bc = 0;
    dc = 0;
    mode = 2'd2;
    repeats = 4'd2;
    edge_start();
    for (int c = 0; c < 70; c++) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL bounce c=%0d got=%h want=%h", c, obs, exp_vec);
      end
      if (c == 5) begin
        checks++;
        if (led1 !== 5'b01000) begin
          errors++;
          $display("FAIL bounce_frame5 got=%b want=01000", led1);
        end
      end
      if (busy1) bc++;
      if (done1) dc++;
      step();
    end
    checks++;
    if (bc != 16 || dc != 1) begin
      errors++;
      $display("FAIL bounce_length busy=%0d done=%0d want busy=16 done=1", bc, dc);
    end
  endtask

  task automatic test_blink_abort();
    int dn;
    logic [N-1:0] want2;
    dn = 0;
    mode = 2'd3;
    repeats = 4'd0;
    edge_start();
    for (int c = 0; c < 201; c++) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL blink c=%0d got=%h want=%h", c, obs, exp_vec);
      end
      want2 = (((c / 2) % 2) == 0) ? 5'b11111 : 5'b00000;
      checks++;
      if (led2 !== want2) begin
        errors++;
        $display("FAIL blink_alt c=%0d got=%b want=%b", c, led2, want2);
      end
      if (done0 | done1 | done2) dn++;
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL blink_abort got=%h want=0", obs);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      if (done0 | done1 | done2) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL blink_no_done count=%0d want=0", dn);
    end
  endtask

  task automatic test_busy_ignore();
    int bc, dc;
    bc = 0;
    dc = 0;
    mode = 2'd1;
    repeats = 4'd2;
    edge_start();
    for (int c = 0; c < 170; c++) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL busy_ignore c=%0d got=%h want=%h", c, obs, exp_vec);
      end
      if (busy0) bc++;
      if (done0) dc++;
      if (c < 19 && (c % 3) == 2) begin
        start = ~start;
        mode = 2'($urandom_range(0, 3));
        repeats = RW'($urandom_range(1, 15));
      end else if (c == 19) begin
        start = 1'b1;
      end
      step();
    end
    checks++;
    if (bc != 40 || dc != 1) begin
      errors++;
      $display("FAIL busy_ignore_length busy=%0d done=%0d want busy=40 done=1", bc, dc);
    end
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL busy_ignore_no_rerun got=%h want=0", obs);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bc, dc;
    mode = 2'd0;
    repeats = 4'd1;
    edge_start();
    repeat (10) step();
    checks++;
    if (led0 !== 5'b00111) begin
      errors++;
      $display("FAIL reset_mid_frame2 got=%b want=00111", led0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_mid got=%h want=0", obs);
    end
    bc = 0;
    dc = 0;
    edge_start();
    for (int c = 0; c < 30; c++) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_rerun c=%0d got=%h want=%h", c, obs, exp_vec);
      end
      if (busy0) bc++;
      if (done0) dc++;
      step();
    end
    checks++;
    if (bc != 24 || dc != 1) begin
      errors++;
      $display("FAIL reset_rerun_length busy=%0d done=%0d want busy=24 done=1", bc, dc);
    end
  endtask

  task automatic test_abort_start();
    start = 1'b0;
    step();
    start = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL abort_blocks_start got=%h want=0", obs);
    end
    step();
    checks++;
    if (obs !== exp_vec || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_hold got=%h want=%h", obs, exp_vec);
    end
    start = 1'b0;
  endtask

  task automatic test_abort_done();
    mode = 2'd3;
    repeats = 4'd1;
    edge_start();
    step();
    checks++;
    if (busy1 !== 1'b1 || led1 !== 5'b00000) begin
      errors++;
      $display("FAIL abort_done_pre busy1=%b led1=%b want busy1=1 led1=00000", busy1, led1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || obs !== '0) begin
      errors++;
      $display("FAIL abort_wins done1=%b busy1=%b obs=%h want done1=0 busy1=0 obs=0",
               done1, busy1, obs);
    end
  endtask

  task automatic test_random();
    int ab;
    for (int it = 0; it < 8; it++) begin
      mode = 2'($urandom_range(0, 3));
      repeats = RW'($urandom_range(0, 3));
      ab = (repeats == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 100)) : -1;
      edge_start();
      for (int c = 0; c < 120; c++) begin
        checks++;
        if (obs !== exp_vec) begin
          errors++;
          $display("FAIL random it=%0d c=%0d got=%h want=%h", it, c, obs, exp_vec);
        end
        abort = (c == ab);
        step();
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL random_end it=%0d got=%h want=0", it, obs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_held();
    test_fill();
    test_bounce();
    test_blink_abort();
    test_busy_ignore();
    test_reset_mid();
    test_abort_start();
    test_abort_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
